// File: rtl/hex_scan_pkg.sv
// Shared types and helpers for the hex digit scanner and related display blocks.
package hex_scan_pkg;
    localparam int NIBBLE_W   = 4;
    localparam int MAX_DIGITS = 16;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_DIGITS-1:0] onehot(input int index, input int n);
        logic [MAX_DIGITS-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            v[i] = (i < n) && (i == index);
        end
        return v;
    endfunction
endpackage

// File: rtl/scan_prescaler.sv
// Free-running 0..PRESCALE-1 counter with a terminal-count flag.
// Latency: count is registered, tc_o is combinational on it; no backpressure.
module scan_prescaler
    import hex_scan_pkg::*;
#(
    parameter int PRESCALE = 1000,
    parameter int CNT_W    = cnt_w(PRESCALE)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);
    logic [CNT_W-1:0] cnt_q;

    assign tc_o    = (cnt_q == CNT_W'(PRESCALE - 1));
    assign count_o = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tc_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/hex_digit_scanner.sv
// Time-multiplexes NUM_DIGITS nibbles onto one digit bus; host writes land in a shadow bank.
// Latency: outputs registered, updated on the same edge as the index; load is never backpressured.
module hex_digit_scanner
    import hex_scan_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int PRESCALE    = 1000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [NUM_DIGITS*NIBBLE_W-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]        blank_in,
    output logic [NIBBLE_W-1:0]          digit_out,
    output logic [NUM_DIGITS-1:0]        digit_sel,
    output logic                         blank_out,
    output logic                         frame_done,
    output logic                         pending
);
    localparam int CNT_W = cnt_w(PRESCALE);
    localparam int IDX_W = cnt_w(NUM_DIGITS);
    localparam int BUS_W = NUM_DIGITS * NIBBLE_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] DEAD_V   = CNT_W'(DEAD_CYCLES);

    logic [CNT_W-1:0]      presc, presc_d;
    logic                  tc, wrap;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BUS_W-1:0]      disp_nib_q, disp_nib_d, shadow_nib_q, shadow_nib_d;
    logic [NUM_DIGITS-1:0] disp_blank_q, disp_blank_d, shadow_blank_q, shadow_blank_d;
    logic                  pending_q, pending_d;
    logic [NIBBLE_W-1:0]   digit_out_q, digit_out_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic                  blank_out_q, blank_out_d, blank_sel;
    logic                  frame_done_q;

    scan_prescaler #(.PRESCALE(PRESCALE), .CNT_W(CNT_W)) u_presc (
        .clk     (clk),
        .rst     (rst),
        .count_o (presc),
        .tc_o    (tc)
    );

    always_comb begin
        wrap           = tc && (idx_q == LAST_IDX);
        presc_d        = tc ? '0 : presc + 1'b1;
        idx_d          = idx_q;
        if (tc) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        disp_nib_d     = disp_nib_q;
        disp_blank_d   = disp_blank_q;
        shadow_nib_d   = shadow_nib_q;
        shadow_blank_d = shadow_blank_q;
        pending_d      = pending_q;
        // A load on the wrap edge goes straight to the display and supersedes the shadow.
        if (wrap) begin
            if (load) begin
                disp_nib_d   = data_in;
                disp_blank_d = blank_in;
            end else if (pending_q) begin
                disp_nib_d   = shadow_nib_q;
                disp_blank_d = shadow_blank_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            shadow_nib_d   = data_in;
            shadow_blank_d = blank_in;
            pending_d      = 1'b1;
        end
        digit_out_d = '0;
        blank_sel   = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                digit_out_d = disp_nib_d[k*NIBBLE_W +: NIBBLE_W];
                blank_sel   = disp_blank_d[k];
            end
        end
        digit_sel_d = NUM_DIGITS'(onehot(int'(idx_d), NUM_DIGITS));
        blank_out_d = blank_sel || (presc_d < DEAD_V);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q          <= '0;
            disp_nib_q     <= '0;
            disp_blank_q   <= '1;
            shadow_nib_q   <= '0;
            shadow_blank_q <= '0;
            pending_q      <= 1'b0;
            digit_out_q    <= '0;
            digit_sel_q    <= NUM_DIGITS'(1);
            blank_out_q    <= 1'b1;
            frame_done_q   <= 1'b0;
        end else begin
            idx_q          <= idx_d;
            disp_nib_q     <= disp_nib_d;
            disp_blank_q   <= disp_blank_d;
            shadow_nib_q   <= shadow_nib_d;
            shadow_blank_q <= shadow_blank_d;
            pending_q      <= pending_d;
            digit_out_q    <= digit_out_d;
            digit_sel_q    <= digit_sel_d;
            blank_out_q    <= blank_out_d;
            frame_done_q   <= wrap;
        end
    end

    assign digit_out  = digit_out_q;
    assign digit_sel  = digit_sel_q;
    assign blank_out  = blank_out_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;
endmodule

// File: tb/tb_hex_digit_scanner.sv
// Directed bench for hex_digit_scanner with NUM_DIGITS=4, PRESCALE=4, DEAD_CYCLES=1.
module tb_hex_digit_scanner;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  blank_in = '0;
    logic [3:0]  digit_out;
    logic [3:0]  digit_sel;
    logic        blank_out;
    logic        frame_done;
    logic        pending;

    int total = 0;
    int bad   = 0;
    int t     = 0;   // edges since reset; slot = (t/4)%4, phase = t%4

    hex_digit_scanner #(.NUM_DIGITS(4), .PRESCALE(4), .DEAD_CYCLES(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_in    (data_in),
        .blank_in   (blank_in),
        .digit_out  (digit_out),
        .digit_sel  (digit_sel),
        .blank_out  (blank_out),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic tick_to(input int target);
        while (t < target) tick();
    endtask

    // Called on a wrap cycle; checks one whole frame and returns on the next wrap cycle.
    task automatic check_frame(input logic [15:0] nib, input logic [3:0] blk, input string tag);
        int s;
        logic [3:0] sel_exp;
        for (int c = 0; c < 16; c++) begin
            s = c / 4;
            sel_exp = 4'b0001 << s;
            chk({tag, "_sel"},   32'(digit_sel),  32'(sel_exp));
            chk({tag, "_dig"},   32'(digit_out),  32'(nib[s*4 +: 4]));
            chk({tag, "_blank"}, 32'(blank_out),  32'(blk[s] || (c % 4 == 0)));
            chk({tag, "_fd"},    32'(frame_done), 32'(c == 0));
            chk({tag, "_pend"},  32'(pending),    32'(0));
            tick();
        end
    endtask

    initial begin
        logic [3:0] sel_exp;
        // 1: reset then free scan with everything blanked
        tick();
        tick();
        rst = 1'b0;
        t = 0;
        chk("rst_sel",   32'(digit_sel),  32'h1);
        chk("rst_dig",   32'(digit_out),  32'h0);
        chk("rst_blank", 32'(blank_out),  32'h1);
        chk("rst_fd",    32'(frame_done), 32'h0);
        chk("rst_pend",  32'(pending),    32'h0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            sel_exp = 4'b0001 << ((t / 4) % 4);
            chk("scan_sel",   32'(digit_sel),  32'(sel_exp));
            chk("scan_blank", 32'(blank_out),  32'h1);
            chk("scan_fd",    32'(frame_done), 32'(t % 16 == 0));
        end

        // 2: mid-frame load waits for the wrap
        data_in = 16'hA5C3; blank_in = 4'b0000; load = 1'b1;
        tick();
        load = 1'b0;
        while (t < 32) begin
            chk("t2_pend", 32'(pending), 32'h1);
            chk("t2_hold", 32'(blank_out), 32'h1);
            tick();
        end
        check_frame(16'hA5C3, 4'b0000, "t2");

        // 3: two loads in one frame, last one wins
        tick_to(49);
        data_in = 16'h1111; load = 1'b1;
        tick();
        load = 1'b0;
        tick_to(54);
        data_in = 16'h2222; load = 1'b1;
        tick();
        load = 1'b0;
        tick_to(60);
        chk("t3_old_dig", 32'(digit_out), 32'hA);
        tick_to(63);
        chk("t3_pend", 32'(pending), 32'h1);
        tick();
        check_frame(16'h2222, 4'b0000, "t3");

        // 4: load on the wrap edge bypasses a pending shadow
        tick_to(85);
        data_in = 16'h9999; load = 1'b1;
        tick();
        load = 1'b0;
        tick_to(95);
        chk("t4_pend_pre", 32'(pending), 32'h1);
        data_in = 16'h7E00; load = 1'b1;
        tick();
        load = 1'b0;
        check_frame(16'h7E00, 4'b0000, "t4");

        // 5: per-digit blank on digit 2
        data_in = 16'hFFFF; blank_in = 4'b0100; load = 1'b1;
        tick();
        load = 1'b0; blank_in = 4'b0000;
        tick_to(128);
        check_frame(16'hFFFF, 4'b0100, "t5");

        // 6: reset mid-scan with a pending write
        data_in = 16'h1234; load = 1'b1;
        tick();
        load = 1'b0;
        tick_to(153);
        chk("t6_sel_pre", 32'(digit_sel), 32'h4);
        chk("t6_pend_pre", 32'(pending), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        t = 0;
        chk("t6_sel",   32'(digit_sel), 32'h1);
        chk("t6_dig",   32'(digit_out), 32'h0);
        chk("t6_blank", 32'(blank_out), 32'h1);
        chk("t6_pend",  32'(pending),   32'h0);
        tick_to(16);
        check_frame(16'h0000, 4'b1111, "t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hex_digit_scanner.md
Name: hex_digit_scanner

Overview:
- Upstream stage of the per-segment hex decoders. Holds NUM_DIGITS hex nibbles and time-multiplexes them onto one shared 4-bit digit bus.
- The digit bus feeds the segment decoders' in1..in4 inputs. It has a one-hot digit select and a blanking flag.
- Host writes go to a shadow bank and are committed only at a frame boundary, so the display never tears.

Parameters:
- NUM_DIGITS, 4: digits scanned; legal range 2..16.
- PRESCALE, 1000: clk cycles each digit is driven; must be >= DEAD_CYCLES+1.
- DEAD_CYCLES, 2: cycles at the start of each slot during which blank_out is forced high (ghost suppression); 0 disables.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle write strobe.
- data_in  in  4*NUM_DIGITS  nibbles; digit k = data_in[4k+3:4k], and bit 4k+3 drives decoder in1 (MSB).
- blank_in  in  NUM_DIGITS  per-digit blank request, sampled with load.
- digit_out  out  4  nibble of the current digit; [3] maps to in1, [0] to in4.
- digit_sel  out  NUM_DIGITS  one-hot active-high enable for the current digit.
- blank_out  out  1  high = segments must be off.
- frame_done  out  1  one-cycle pulse when the scan wraps to digit 0.
- pending  out  1  high while shadow data awaits commit.

Behaviour:
- Reset (rst=1 at an edge, also mid-scan):
  - prescaler=0, index=0.
  - display bank nibbles=0 and blank bits all 1.
  - shadow cleared; pending=0.
  - digit_out=0, digit_sel=1 (digit 0), blank_out=1, frame_done=0.
- Prescaler:
  - Counts 0..PRESCALE-1.
  - At terminal count it returns to 0 and the index advances; index NUM_DIGITS-1 wraps to 0.
  - Counter widths are $clog2 of the range, minimum 1 bit.
- All outputs are registered and change on the same edge as the index.
  - digit_out = display nibble[index].
  - digit_sel = 1<<index.
  - blank_out = display blank[index] OR (prescaler < DEAD_CYCLES).
- Wrap edge (index goes NUM_DIGITS-1 -> 0):
  - frame_done=1 for exactly that cycle.
  - If pending=1, shadow is copied into the display bank and pending clears; digit 0 shows the new data in that same cycle.
- load with no wrap on the same edge: shadow <= {data_in, blank_in}; pending=1.
  - If pending was already 1, the last write wins and nothing is queued.
- load on the wrap edge: data_in/blank_in go directly to the display bank, bypassing the shadow. pending is 0 afterwards; older shadow contents are discarded.
- Display bank never changes except at the wrap edge or on reset.
- load while rst=1 is ignored.
- No back-pressure: load is always accepted.

Decomposition:
- Package hex_scan_pkg:
  - NIBBLE_W=4.
  - Function onehot(index, n).
  - Localparam helpers for counter widths.
- Sub-module scan_prescaler (clk, rst, terminal-count output, count value). Reused by later display blocks.
- Bank registers and the output mux stay in the top module.

Test Plan:
Bench configuration for all scenarios: NUM_DIGITS=4, PRESCALE=4, DEAD_CYCLES=1.
1. Release reset:
   - Required: digit_sel sequence 0001, 0010, 0100, 1000, 0001, with 4 cycles per slot.
   - Required: blank_out=1 throughout; frame_done pulses every 16 cycles.
2. load data_in=16'hA5C3, blank_in=0000 mid-frame:
   - Required: pending=1 until the wrap edge.
   - Required: then digit_out sequence 3, C, 5, A.
   - Required: blank_out is 1 in the first cycle of each slot and 0 in the other 3.
3. Two loads in one frame, 16'h1111 then 16'h2222:
   - Required: only 2 is ever displayed.
   - Required: pending clears at the wrap edge.
4. load 16'h7E00 exactly on the wrap edge:
   - Required: digit 0 shows 0 in that cycle and digit 2 shows E.
   - Required: pending stays 0.
5. blank_in=0100 with data 16'hFFFF:
   - Required: blank_out=1 for the whole digit-2 slot.
   - Required: other slots are blank only in their dead cycle.
6. Assert rst in slot 2 while pending=1:
   - Required: next cycle digit_sel=0001, digit_out=0, blank_out=1, pending=0.
   - Required: old data is not shown again.
